// File: rtl/rr_bus_arbiter.sv
// Round-robin arbiter: one registered grant per request burst, with hold timeout and one idle bubble between grants.
// Grant appears one cycle after the request; a non-owner waits for the owner to release or time out.
module rr_bus_arbiter #(
  parameter int N        = 4,
  parameter int IDX_W    = $clog2(N),
  parameter int MAX_HOLD = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N-1:0]     req,
  output logic [N-1:0]     grant,
  output logic [IDX_W-1:0] grant_idx,
  output logic             grant_valid,
  output logic             timeout
);

  localparam int CNT_W = (MAX_HOLD < 1) ? 1 : $clog2(MAX_HOLD + 1);
  localparam logic [CNT_W-1:0] HOLD_LAST = (MAX_HOLD == 0) ? '0 : CNT_W'(MAX_HOLD - 1);

  typedef enum logic {
    IDLE    = 1'b0,
    GRANTED = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [N-1:0]     grant_q, grant_d;
  logic [IDX_W-1:0] grant_idx_q, grant_idx_d;
  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic [CNT_W-1:0] hold_q, hold_d;
  logic             timeout_q, timeout_d;

  logic [IDX_W-1:0] pick_idx;
  logic             pick_vld;
  logic [N-1:0]     others;
  logic             release_now;

  // Scan downward so the lowest offset from ptr_q is the one that sticks.
  always_comb begin
    pick_idx = '0;
    pick_vld = 1'b0;
    for (int off = N - 1; off >= 0; off--) begin
      if (req[ptr_q + IDX_W'(off)]) begin
        pick_idx = ptr_q + IDX_W'(off);
        pick_vld = 1'b1;
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    grant_idx_d = grant_idx_q;
    ptr_d       = ptr_q;
    hold_d      = hold_q;
    timeout_d   = 1'b0;
    others      = req & ~grant_q;
    release_now = 1'b0;

    case (state_q)
      IDLE: begin
        if (pick_vld) begin
          state_d           = GRANTED;
          grant_d           = '0;
          grant_d[pick_idx] = 1'b1;
          grant_idx_d       = pick_idx;
          hold_d            = '0;
        end
      end
      GRANTED: begin
        release_now = !req[grant_idx_q] ||
                      ((MAX_HOLD != 0) && (hold_q == HOLD_LAST) && (|others));
        if (release_now) begin
          state_d     = IDLE;
          grant_d     = '0;
          grant_idx_d = '0;
          ptr_d       = grant_idx_q + IDX_W'(1);
          hold_d      = '0;
          // An owner dropping on the timeout cycle counts as a voluntary release.
          timeout_d   = req[grant_idx_q];
        end else if (hold_q != HOLD_LAST) begin
          hold_d = hold_q + CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      grant_q     <= '0;
      grant_idx_q <= '0;
      ptr_q       <= '0;
      hold_q      <= '0;
      timeout_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      grant_idx_q <= grant_idx_d;
      ptr_q       <= ptr_d;
      hold_q      <= hold_d;
      timeout_q   <= timeout_d;
    end
  end

  assign grant       = grant_q;
  assign grant_idx   = grant_idx_q;
  assign grant_valid = |grant_q;
  assign timeout     = timeout_q;

endmodule
